// File: rtl/multi_pulse_gen.sv
// Multi-channel level-to-pulse converter: per-channel edge detect + PULSE_LEN-cycle registered pulse.
// Optional feature macro: PULSE_SYNC_EN adds a 2-flop synchroniser per channel ahead of edge detect.

module multi_pulse_gen_ch #(
  parameter int PULSE_LEN = 1,
  parameter int RETRIG    = 1,
  parameter int CW        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] edge_sel,
  input  logic       miss_clr,
  input  logic       lvl_i,
  output logic       pulse_o,
  output logic       miss_o
);

  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] ZERO   = '0;
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            miss_q, miss_d;
  logic            lvl_q, lvl_d;
  logic            lvl_s;
  logic            rise, fall, edge_det, acc;

`ifdef PULSE_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = lvl_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign lvl_s = sync2_q;
`else
  assign lvl_s = lvl_i;
`endif

  // lvl_q tracks independent of EN so re-enabling never manufactures an edge
  always_comb begin
    lvl_d = lvl_s;
    rise  = lvl_s & ~lvl_q;
    fall  = ~lvl_s & lvl_q;
    case (edge_sel)
      2'b01:   edge_det = fall;
      2'b10:   edge_det = rise | fall;
      default: edge_det = rise;
    endcase
    acc = edge_det & en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      miss_q  <= miss_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = ACTIVE;
          cnt_d   = RELOAD;
        end
      end
      ACTIVE: begin
        // cnt==0 reload is the back-to-back case and never counts as a miss
        if (acc && ((cnt_q == ZERO) || (RETRIG != 0))) begin
          cnt_d = RELOAD;
        end else if (cnt_q != ZERO) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
    endcase
  end

  // Set beats clear when a miss and MISS_CLR coincide
  always_comb begin
    pulse_d = (state_d == ACTIVE);
    miss_d  = miss_q;
    if (miss_clr) miss_d = 1'b0;
    if ((state_q == ACTIVE) && acc && (cnt_q != ZERO) && (RETRIG == 0)) miss_d = 1'b1;
  end

  assign pulse_o = pulse_q;
  assign miss_o  = miss_q;

endmodule

module multi_pulse_gen #(
  parameter int NUM_CH    = 4,
  parameter int PULSE_LEN = 1,
  parameter int RETRIG    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [1:0]        EDGE_SEL,
  input  logic              MISS_CLR,
  input  logic [NUM_CH-1:0] LVL_SIG,
  output logic [NUM_CH-1:0] PULSE_GEN,
  output logic [NUM_CH-1:0] BUSY,
  output logic [NUM_CH-1:0] PULSE_MISS
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      multi_pulse_gen_ch #(
        .PULSE_LEN (PULSE_LEN),
        .RETRIG    (RETRIG),
        .CW        (CW)
      ) u_ch (
        .clk      (CLK),
        .rst      (RST),
        .en       (EN),
        .edge_sel (EDGE_SEL),
        .miss_clr (MISS_CLR),
        .lvl_i    (LVL_SIG[i]),
        .pulse_o  (PULSE_GEN[i]),
        .miss_o   (PULSE_MISS[i])
      );
    end
  endgenerate

  assign BUSY = PULSE_GEN;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Bench for multi_pulse_gen: four instances (len 1 / len 4 retrig / len 4 no-retrig / len 8),
// expected pulses queued by the stimulus and matched by a monitor as each pulse ends.

module tb_multi_pulse_gen;

`ifdef PULSE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0;
  logic RST, EN, MISS_CLR;
  logic [1:0] EDGE_SEL;
  logic [3:0][3:0] lvl, pg, bz, ms;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct { int inst; int ch; int start; int len; } exp_t;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  multi_pulse_gen #(.NUM_CH(4), .PULSE_LEN(1), .RETRIG(1)) u_a (
    .CLK(CLK), .RST(RST), .EN(EN), .EDGE_SEL(EDGE_SEL), .MISS_CLR(MISS_CLR),
    .LVL_SIG(lvl[0]), .PULSE_GEN(pg[0]), .BUSY(bz[0]), .PULSE_MISS(ms[0]));
  multi_pulse_gen #(.NUM_CH(4), .PULSE_LEN(4), .RETRIG(1)) u_b (
    .CLK(CLK), .RST(RST), .EN(EN), .EDGE_SEL(EDGE_SEL), .MISS_CLR(MISS_CLR),
    .LVL_SIG(lvl[1]), .PULSE_GEN(pg[1]), .BUSY(bz[1]), .PULSE_MISS(ms[1]));
  multi_pulse_gen #(.NUM_CH(4), .PULSE_LEN(4), .RETRIG(0)) u_c (
    .CLK(CLK), .RST(RST), .EN(EN), .EDGE_SEL(EDGE_SEL), .MISS_CLR(MISS_CLR),
    .LVL_SIG(lvl[2]), .PULSE_GEN(pg[2]), .BUSY(bz[2]), .PULSE_MISS(ms[2]));
  multi_pulse_gen #(.NUM_CH(4), .PULSE_LEN(8), .RETRIG(1)) u_d (
    .CLK(CLK), .RST(RST), .EN(EN), .EDGE_SEL(EDGE_SEL), .MISS_CLR(MISS_CLR),
    .LVL_SIG(lvl[3]), .PULSE_GEN(pg[3]), .BUSY(bz[3]), .PULSE_MISS(ms[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int inst, input int ch, input int start, input int len);
    exp_t e;
    e.inst = inst; e.ch = ch; e.start = start; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: measures each pulse (start cycle, length) and matches the oldest expectation for that channel
  bit run [4][4];
  int st  [4][4];
  int ln  [4][4];

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (pg[i][c] === 1'b1) begin
          if (!run[i][c]) begin
            run[i][c] = 1'b1;
            st[i][c]  = cyc;
            ln[i][c]  = 1;
            chk($sformatf("busy_i%0d_c%0d", i, c), {31'd0, bz[i][c]}, 32'd1);
          end else begin
            ln[i][c] = ln[i][c] + 1;
          end
        end else if (run[i][c]) begin
          int idx;
          run[i][c] = 1'b0;
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j].inst == i && exp_q[j].ch == c) idx = j;
          n_chk++;
          if (idx < 0) begin
            $display("FAIL pulse_i%0d_c%0d: got unexpected pulse start %0d len %0d, expected none",
                     i, c, st[i][c], ln[i][c]);
          end else begin
            if (st[i][c] == exp_q[idx].start && ln[i][c] == exp_q[idx].len) n_pass++;
            else $display("FAIL pulse_i%0d_c%0d: got start %0d len %0d, expected start %0d len %0d",
                          i, c, st[i][c], ln[i][c], exp_q[idx].start, exp_q[idx].len);
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1; EN = 1'b1; EDGE_SEL = 2'b00; MISS_CLR = 1'b0; lvl = '0;
    step(2);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_i%0d", i), {20'd0, pg[i], bz[i], ms[i]}, 32'd0);
    RST = 1'b0;
    step(3);

    // len 1: single rise held high -> one 1-cycle pulse
    lvl[0][0] = 1'b1; push(0, 0, cyc + LAT, 1);
    step(10);
    lvl[0][0] = 1'b0;
    step(6);

    // len 1, both edges: three edges on consecutive cycles -> 3 cycles continuous
    EDGE_SEL = 2'b10;
    lvl[0][3] = 1'b1; push(0, 3, cyc + LAT, 3);
    step(1); lvl[0][3] = 1'b0;
    step(1); lvl[0][3] = 1'b1;
    step(6);
    EDGE_SEL = 2'b00; lvl[0][3] = 1'b0;
    step(6);

    // simultaneous rises on all channels
    lvl[0] = 4'hF;
    for (int c = 0; c < 4; c++) push(0, c, cyc + LAT, 1);
    step(6);
    lvl[0] = 4'h0;
    step(6);

    // reserved select decodes as rise
    EDGE_SEL = 2'b11;
    lvl[0][1] = 1'b1; push(0, 1, cyc + LAT, 1);
    step(6);
    lvl[0][1] = 1'b0;
    step(6);

    // fall select: rise ignored, fall pulses
    EDGE_SEL = 2'b01;
    lvl[0][2] = 1'b1;
    step(6);
    lvl[0][2] = 1'b0; push(0, 2, cyc + LAT, 1);
    step(6);

    // len 4, both edges: rise then fall 6 cycles later -> two 4-cycle pulses, 2 low between
    EDGE_SEL = 2'b10;
    lvl[1][1] = 1'b1; push(1, 1, cyc + LAT, 4);
    step(6);
    lvl[1][1] = 1'b0; push(1, 1, cyc + LAT, 4);
    step(8);
    EDGE_SEL = 2'b00;

    // second rise 2 cycles into pulse: retrig -> 6 cycles; no-retrig -> 4 cycles + miss
    lvl[1][2] = 1'b1; lvl[2][2] = 1'b1;
    push(1, 2, cyc + LAT, 6); push(2, 2, cyc + LAT, 4);
    step(1); lvl[1][2] = 1'b0; lvl[2][2] = 1'b0;
    step(1); lvl[1][2] = 1'b1; lvl[2][2] = 1'b1;
    step(8);
    chk("retrig_no_miss", {28'd0, ms[1]}, 32'h0);
    chk("noretrig_miss", {28'd0, ms[2]}, 32'h4);
    step(3);
    chk("miss_sticky", {28'd0, ms[2]}, 32'h4);
    MISS_CLR = 1'b1; step(1); MISS_CLR = 1'b0;
    chk("miss_clr", {28'd0, ms[2]}, 32'h0);

    // miss set and MISS_CLR in the same cycle: set wins
    lvl[2][3] = 1'b1; push(2, 3, cyc + LAT, 4);
    step(1); lvl[2][3] = 1'b0;
    step(1); lvl[2][3] = 1'b1;
    step(LAT - 1);
    MISS_CLR = 1'b1; step(1); MISS_CLR = 1'b0;
    chk("miss_set_wins", {28'd0, ms[2]}, 32'h8);
    step(6);
    MISS_CLR = 1'b1; step(1); MISS_CLR = 1'b0;
    chk("miss_clr2", {28'd0, ms[2]}, 32'h0);
    lvl[2][3] = 1'b0; lvl[2][2] = 1'b0; lvl[1][2] = 1'b0;
    step(4);

    // edge exactly at cnt==0 on no-retrig: seamless 8 cycles, no miss
    EDGE_SEL = 2'b10;
    lvl[2][0] = 1'b1; push(2, 0, cyc + LAT, 8);
    step(4);
    lvl[2][0] = 1'b0;
    step(10);
    chk("b2b_no_miss", {28'd0, ms[2]}, 32'h0);
    EDGE_SEL = 2'b00;

    // edge while disabled, enable with level still high -> no pulse
    EN = 1'b0;
    lvl[0][2] = 1'b1;
    step(LAT + 1);
    EN = 1'b1;
    step(8);
    lvl[0][2] = 1'b0;
    step(2);

    // disabling mid-pulse lets the active pulse complete
    lvl[1][0] = 1'b1; push(1, 0, cyc + LAT, 4);
    step(LAT + 1);
    EN = 1'b0;
    step(6);
    EN = 1'b1; lvl[1][0] = 1'b0;
    step(2);

    // reset mid-pulse on len 8: drop immediately, fresh pulse after release with level high
    lvl[3][1] = 1'b1; push(3, 1, cyc + LAT, 3);
    step(LAT + 2);
    #2 RST = 1'b1;
    #1 chk("rst_async", {24'd0, pg[3], bz[3]}, 32'd0);
    step(2);
    RST = 1'b0; push(3, 1, cyc + LAT, 8);
    step(12);
    lvl[3][1] = 1'b0;
    step(4);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
